// File: rtl/zxw_alu_pkg.sv
// Shared definitions for the ALU sequencing/capture stage and its logic-unit sibling.
package zxw_alu_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int CW_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GOT_A = 3'd1,
        S_GOT_B = 3'd2,
        S_EXEC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

endpackage

// File: rtl/zxw_alu_seq_ctrl.sv
// Loads A then B from a shared bus, drives the logic unit, and captures its
// result behind a valid/ack handshake with zero flag and operation counter.
module zxw_alu_seq_ctrl
    import zxw_alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          load,
    input  logic [1:0]    sel,
    input  logic          start,
    input  logic          ack,
    input  logic [DW:0]   fun_in,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic          fs2,
    output logic          fs1,
    output logic [DW:0]   result,
    output logic          valid,
    output logic          zero,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    state_t        r_state;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [1:0]    r_fs;
    logic [DW:0]   r_result;
    logic          r_valid;
    logic          r_zero;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_fs     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_a     <= din;
                        r_state <= S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (load) begin
                        r_b     <= din;
                        r_state <= S_GOT_B;
                    end
                end
                S_GOT_B: begin
                    // start takes priority; a coincident load is dropped
                    if (start) begin
                        r_fs    <= sel;
                        r_state <= S_EXEC;
                    end else if (load) begin
                        r_b <= din;
                    end
                end
                S_EXEC: begin
                    // logic unit has had a full cycle on the registered operands
                    r_result <= fun_in;
                    r_zero   <= (fun_in == '0);
                    r_valid  <= 1'b1;
                    r_cnt    <= r_cnt + CW'(1);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign fs2      = r_fs[1];
    assign fs1      = r_fs[0];
    assign result   = r_result;
    assign valid    = r_valid;
    assign zero     = r_zero;
    assign op_count = r_cnt;
    assign busy     = (r_state == S_EXEC) || (r_state == S_DONE);

endmodule

// File: tb/tb_zxw_alu_seq_ctrl.sv
// Bench for zxw_alu_seq_ctrl with a behavioural logic unit and a result scoreboard.
module tb_zxw_alu_seq_ctrl;
    import zxw_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = '0;
    logic       load = 1'b0;
    logic [1:0] sel = '0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic [4:0] fun_in;
    logic [3:0] A, B;
    logic       fs2, fs1;
    logic [4:0] result;
    logic       valid, zero, busy;
    logic [3:0] op_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] res;
        logic       z;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_cnt = '0;
    logic       prev_v = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [4:0] lu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            OP_NOT:  return ~{1'b0, a};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            default: return {a[0], a[3], a[3:1]};
        endcase
    endfunction

    // sibling logic unit
    assign fun_in = lu(A, B, {fs2, fs1});

    zxw_alu_seq_ctrl #(.DW(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .sel(sel), .start(start),
        .ack(ack), .fun_in(fun_in), .A(A), .B(B), .fs2(fs2), .fs1(fs1),
        .result(result), .valid(valid), .zero(zero), .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, expv, $time);
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] d, input logic st,
                         input logic [1:0] s, input logic ak);
        load = ld; din = d; start = st; sel = s; ack = ak;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; ack = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        exp_t e;
        m_cnt  = m_cnt + 4'd1;
        e.res  = lu(a, b, s);
        e.z    = (e.res == 5'd0);
        e.cnt  = m_cnt;
        sb.push_back(e);
    endtask

    task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s, input bit do_ack);
        drive(1'b1, a, 1'b0, 2'b00, 1'b0);
        drive(1'b1, b, 1'b0, 2'b00, 1'b0);
        push_exp(a, b, s);
        drive(1'b0, 4'h0, 1'b1, s, 1'b0);
        chk("exec_busy", busy, 1);
        chk("exec_valid", valid, 0);
        chk("fs", {fs2, fs1}, s);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("done_valid", valid, 1);
        chk("opA", A, a);
        chk("opB", B, b);
        if (do_ack) begin
            drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);
            chk("ack_valid", valid, 0);
            chk("ack_busy", busy, 0);
        end
    endtask

    // scoreboard: pop on each rising edge of valid
    always @(negedge clk) begin
        if (!rst && valid && !prev_v) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_res", result, e.res);
                chk("sb_zero", zero, e.z);
                chk("sb_cnt", op_count, e.cnt);
            end
        end
        prev_v <= valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_wrap;
        saw_wrap = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {A, B, fs2, fs1, result, valid, zero, busy, op_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // AND path
        txn(4'b1010, 4'b0110, OP_AND, 1'b0);
        chk("and_res", result, 5'b00010);
        chk("and_zero", zero, 0);
        chk("and_cnt", op_count, 1);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);

        // NOT and shift
        txn(4'b0101, 4'b0000, OP_NOT, 1'b0);
        chk("not_res", result, 5'b11010);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);
        txn(4'b1001, 4'b0011, OP_SHR, 1'b0);
        chk("shr_res", result, 5'b11100);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);

        // zero flag and backpressure
        txn(4'b0000, 4'b1111, OP_AND, 1'b0);
        chk("zero_flag", zero, 1);
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 4'hA, ~i[0], 2'b10, 1'b0);
            chk("hold", {valid, zero, result, A, B, fs2, fs1},
                {1'b1, 1'b1, 5'd0, 4'h0, 4'hF, 2'b01});
        end
        drive(1'b1, 4'h7, 1'b1, 2'b11, 1'b1);
        chk("ack_coll_valid", valid, 0);
        chk("ack_coll_busy", busy, 0);
        chk("ack_coll_A", A, 4'h0);

        // start ignored in IDLE and GOT_A
        drive(1'b0, 4'h0, 1'b1, 2'b00, 1'b0);
        chk("idle_start", busy, 0);
        drive(1'b1, 4'h7, 1'b0, 2'b00, 1'b0);
        chk("loadA", A, 4'h7);
        drive(1'b0, 4'h0, 1'b1, 2'b00, 1'b0);
        chk("gota_start_busy", busy, 0);
        chk("gota_start_B", B, 4'hF);
        drive(1'b1, 4'h8, 1'b0, 2'b00, 1'b0);
        chk("loadB", B, 4'h8);
        push_exp(4'h7, 4'h8, OP_OR);
        drive(1'b0, 4'h0, 1'b1, OP_OR, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("or_res", result, 5'b01111);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);

        // B overwrite in GOT_B, then start+load collision
        drive(1'b1, 4'b1110, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 4'b0101, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 4'b0011, 1'b0, 2'b00, 1'b0);
        chk("b_overwrite", B, 4'b0011);
        push_exp(4'b1110, 4'b0011, OP_AND);
        drive(1'b1, 4'hF, 1'b1, OP_AND, 1'b0);
        chk("coll_busy", busy, 1);
        chk("coll_B", B, 4'b0011);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("coll_res", result, 5'b00010);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);

        // counter wrap across 16 transactions
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a, b;
            logic [1:0] s;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 2'($urandom_range(0, 3));
            txn(a, b, s, 1'b0);
            if (m_cnt == 4'd0) begin
                saw_wrap = 1'b1;
                chk("wrap_cnt", op_count, 0);
            end
            drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);
        end
        chk("wrap_seen", saw_wrap, 1);

        // reset during EXEC
        drive(1'b1, 4'h3, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 4'h5, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 4'h0, 1'b1, OP_OR, 1'b0);
        chk("pre_rst_exec_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_exec", {A, B, fs2, fs1, result, valid, zero, busy, op_count}, 0);
        sb.delete();
        m_cnt = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // reset during DONE
        drive(1'b1, 4'h6, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 4'h3, 1'b0, 2'b00, 1'b0);
        push_exp(4'h6, 4'h3, OP_OR);
        drive(1'b0, 4'h0, 1'b1, OP_OR, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
        chk("pre_rst_done_valid", valid, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_done", {A, B, fs2, fs1, result, valid, zero, busy, op_count}, 0);
        sb.delete();
        m_cnt = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // normal operation after abort
        txn(4'b1100, 4'b1010, OP_OR, 1'b0);
        chk("post_rst_res", result, 5'b01110);
        chk("post_rst_cnt", op_count, 1);
        drive(1'b0, 4'h0, 1'b0, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
